// File: rtl/axis_video_sink.sv
// axis_video_sink
//   AXI4-Stream video slave for an RGB888 pixel stream (tuser = start of frame,
//   tlast = end of line). It locks onto start-of-frame, tracks the pixel
//   position, packs each pixel to RGB444 and issues a held write request to a
//   framebuffer at linear address y*H_RES+x. Malformed lines and frames raise
//   one-cycle error pulses.
//
//   Optional feature: define AXIS_SINK_ERRCNT_EN to build the saturating
//   16-bit error counter on err_count. Without it err_count reads zero.
module axis_video_sink #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [23:0]       tdata,
    input  logic              tvalid,
    input  logic              tuser,
    input  logic              tlast,
    output logic              tready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              fb_we,
    input  logic              fb_wready,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic [15:0]       err_count
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [X_W-1:0]    X_ZERO    = {X_W{1'b0}};
    localparam logic [Y_W-1:0]    Y_ZERO    = {Y_W{1'b0}};
    localparam logic [X_W-1:0]    X_ONE     = X_W'(1'b1);
    localparam logic [Y_W-1:0]    Y_ONE     = Y_W'(1'b1);
    localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Truncating RGB888 -> RGB444 pack: keep the top nibble of each channel.
    function automatic logic [11:0] pack_rgb444(input logic [23:0] rgb);
        pack_rgb444 = {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

    // Receive state and position
    state_t            state_r;
    state_t            state_nx_s;
    logic [X_W-1:0]    x_r;
    logic [X_W-1:0]    x_nx_s;
    logic [Y_W-1:0]    y_r;
    logic [Y_W-1:0]    y_nx_s;
    // addr_r is the address of the next pixel; base_r is the address of x=0
    // on the current line, so a short or dropped line can jump to the next
    // line start without a multiplier.
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nx_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] base_nx_s;

    // Per-beat decisions
    logic              tready_s;
    logic              accept_s;
    logic              write_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              restart_s;
    logic              line_end_s;
    logic              done_s;
    logic              line_err_s;
    logic              frame_err_s;

    // Registered outputs
    logic              fb_we_r;
    logic [ADDR_W-1:0] fb_addr_r;
    logic [11:0]       fb_data_r;
    logic              frame_done_r;
    logic              line_err_r;
    logic              frame_err_r;

    // A beat may enter whenever the write slot is free or about to drain;
    // in SEEK/DROP beats are normally discarded so the slot is not consulted.
    always_comb begin
        tready_s = 1'b0;
        if (reset) begin
            tready_s = 1'b0;
        end else begin
            tready_s = (state_r == ST_SEEK) || (state_r == ST_DROP) ||
                       !fb_we_r || fb_wready;
        end
    end

    assign accept_s = tvalid && tready_s;

    // Next-state, position and address update for an accepted beat
    always_comb begin
        state_nx_s  = state_r;
        x_nx_s      = x_r;
        y_nx_s      = y_r;
        addr_nx_s   = addr_r;
        base_nx_s   = base_r;
        write_s     = 1'b0;
        wr_addr_s   = addr_r;
        restart_s   = 1'b0;
        line_end_s  = 1'b0;
        done_s      = 1'b0;
        line_err_s  = 1'b0;
        frame_err_s = 1'b0;

        if (accept_s) begin
            case (state_r)
                ST_SEEK: begin
                    if (tuser) begin
                        restart_s = 1'b1;
                    end else begin
                        restart_s = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // tuser outranks tlast; a SOF anywhere but (0,0) is a frame error
                    if (tuser) begin
                        restart_s = 1'b1;
                        if ((x_r != X_ZERO) || (y_r != Y_ZERO)) begin
                            frame_err_s = 1'b1;
                        end else begin
                            frame_err_s = 1'b0;
                        end
                    end else begin
                        write_s = 1'b1;
                        if (tlast) begin
                            line_end_s = 1'b1;
                            if (x_r != X_LAST) begin
                                line_err_s = 1'b1;
                            end else begin
                                line_err_s = 1'b0;
                            end
                        end else if (x_r == X_LAST) begin
                            // Line too long: keep this pixel, discard the rest
                            line_err_s = 1'b1;
                            state_nx_s = ST_DROP;
                        end else begin
                            x_nx_s    = x_r + X_ONE;
                            addr_nx_s = addr_r + A_ONE;
                        end
                    end
                end
                ST_DROP: begin
                    if (tuser) begin
                        restart_s   = 1'b1;
                        frame_err_s = 1'b1;
                    end else if (tlast) begin
                        line_end_s = 1'b1;
                    end else begin
                        line_end_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s = ST_SEEK;
                    x_nx_s     = X_ZERO;
                    y_nx_s     = Y_ZERO;
                    addr_nx_s  = A_ZERO;
                    base_nx_s  = A_ZERO;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end

        if (restart_s) begin
            // Beat becomes pixel (0,0) of a fresh frame
            write_s    = 1'b1;
            wr_addr_s  = A_ZERO;
            x_nx_s     = X_ONE;
            y_nx_s     = Y_ZERO;
            addr_nx_s  = A_ONE;
            base_nx_s  = A_ZERO;
            state_nx_s = ST_ACTIVE;
        end else if (line_end_s) begin
            x_nx_s = X_ZERO;
            if (y_r == Y_LAST) begin
                done_s     = 1'b1;
                y_nx_s     = Y_ZERO;
                addr_nx_s  = A_ZERO;
                base_nx_s  = A_ZERO;
                state_nx_s = ST_SEEK;
            end else begin
                y_nx_s     = y_r + Y_ONE;
                addr_nx_s  = base_r + LINE_STEP;
                base_nx_s  = base_r + LINE_STEP;
                state_nx_s = ST_ACTIVE;
            end
        end else begin
            line_end_s = 1'b0;
        end
    end

    // State, position and address registers
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_r <= ST_SEEK;
            x_r     <= X_ZERO;
            y_r     <= Y_ZERO;
            addr_r  <= A_ZERO;
            base_r  <= A_ZERO;
        end else begin
            state_r <= state_nx_s;
            x_r     <= x_nx_s;
            y_r     <= y_nx_s;
            addr_r  <= addr_nx_s;
            base_r  <= base_nx_s;
        end
    end

    // Framebuffer write slot: load on a written beat, hold until fb_wready
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= A_ZERO;
            fb_data_r <= 12'h000;
        end else if (write_s) begin
            fb_we_r   <= 1'b1;
            fb_addr_r <= wr_addr_s;
            fb_data_r <= pack_rgb444(tdata);
        end else if (fb_wready) begin
            fb_we_r   <= 1'b0;
        end else begin
            fb_we_r   <= fb_we_r;
        end
    end

    // One-cycle status pulses
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            frame_done_r <= 1'b0;
            line_err_r   <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            line_err_r   <= line_err_s;
            frame_err_r  <= frame_err_s;
        end
    end

`ifdef AXIS_SINK_ERRCNT_EN
    logic [15:0] err_count_r;

    // Saturating count of line and frame error events
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            err_count_r <= 16'h0000;
        end else if ((line_err_s || frame_err_s) && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 16'h0000;
`endif

    assign tready     = tready_s;
    assign fb_we      = fb_we_r;
    assign fb_addr    = fb_addr_r;
    assign fb_data    = fb_data_r;
    assign frame_done = frame_done_r;
    assign line_err   = line_err_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_axis_video_sink.sv
// Scoreboard bench for axis_video_sink at H_RES=4, V_RES=2.
// Stimulus pushes expected framebuffer writes and status pulses into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_axis_video_sink;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] P_FD   = 3'b100;
    localparam logic [2:0] P_LE   = 3'b010;
    localparam logic [2:0] P_FE   = 3'b001;

    logic          pixel_clk;
    logic          reset;
    logic [23:0]   tdata;
    logic          tvalid;
    logic          tuser;
    logic          tlast;
    logic          tready;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_data;
    logic          fb_we;
    logic          fb_wready;
    logic          frame_done;
    logic          line_err;
    logic          frame_err;
    logic [15:0]   err_count;

    axis_video_sink #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tuser     (tuser),
        .tlast     (tlast),
        .tready    (tready),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_wready (fb_wready),
        .frame_done(frame_done),
        .line_err  (line_err),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int errors = 0;
    int checks = 0;

    logic [AW+11:0] wr_q[$];
    logic [2:0]     pulse_q[$];

    // Requests from the stimulus process, serviced by the monitor
    logic        chk_en  = 1'b0;
    logic [4:0]  chk_val = 5'b00000;
    logic        cnt_en  = 1'b0;
    logic [15:0] cnt_val = 16'h0000;
    logic        to_req  = 1'b0;
    logic        end_req = 1'b0;
    string       chk_name = "none";

    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [11:0]   hold_data;

    // Monitor: compares presented writes/pulses against the scoreboard
    always @(negedge pixel_clk) begin
        logic [AW+11:0] exp_w;
        logic [2:0]     exp_p;
        logic [2:0]     pv;
        if (chk_en) begin
            checks++;
            if ({tready, fb_we, frame_done, line_err, frame_err} !== chk_val) begin
                errors++;
                $display("FAIL %s: {tready,fb_we,fd,le,fe} got %b want %b", chk_name,
                         {tready, fb_we, frame_done, line_err, frame_err}, chk_val);
            end
        end
        if (cnt_en) begin
            checks++;
            if (err_count !== cnt_val) begin
                errors++;
                $display("FAIL %s: err_count got %0d want %0d", chk_name, err_count, cnt_val);
            end
        end
        if (to_req) begin
            checks++;
            errors++;
            $display("FAIL %s: beat not accepted within cycle budget", chk_name);
        end
        if (end_req) begin
            checks++;
            if (wr_q.size() != 0 || pulse_q.size() != 0) begin
                errors++;
                $display("FAIL drain: writes left %0d want 0, pulses left %0d want 0",
                         wr_q.size(), pulse_q.size());
            end
        end
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (fb_addr !== hold_addr || fb_data !== hold_data || fb_we !== 1'b1) begin
                    errors++;
                    $display("FAIL hold: addr/data/we got %0d/%h/%b want %0d/%h/1",
                             fb_addr, fb_data, fb_we, hold_addr, hold_data);
                end
            end
            hold_v    = fb_we && !fb_wready;
            hold_addr = fb_addr;
            hold_data = fb_data;
            if (fb_we && fb_wready) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected write addr %0d data %h, want none",
                             fb_addr, fb_data);
                end else begin
                    exp_w = wr_q.pop_front();
                    if ({fb_addr, fb_data} !== exp_w) begin
                        errors++;
                        $display("FAIL write: addr/data got %0d/%h want %0d/%h",
                                 fb_addr, fb_data, exp_w[AW+11:12], exp_w[11:0]);
                    end
                end
            end
            pv = {frame_done, line_err, frame_err};
            if (pv != 3'b000) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: unexpected {fd,le,fe} %b, want none", pv);
                end else begin
                    exp_p = pulse_q.pop_front();
                    if (pv !== exp_p) begin
                        errors++;
                        $display("FAIL pulse: {fd,le,fe} got %b want %b", pv, exp_p);
                    end
                end
            end
        end
    end

    function automatic logic [23:0] pix(input logic [3:0] p);
        pix = {p, 4'h9, p, 4'h6, p, 4'h3};
    endfunction

    // Drive one beat; returns at posedge+1 after acceptance
    task automatic send(input logic [23:0] d, input logic u, input logic l);
        int waited;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        waited = 0;
        @(negedge pixel_clk);
        while (!tready && waited < 50) begin
            @(negedge pixel_clk);
            waited++;
        end
        if (!tready) begin
            to_req = 1'b1;
            @(negedge pixel_clk);
            #1 to_req = 1'b0;
        end
        @(posedge pixel_clk);
        #1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    // Beat that must be written at address a with packed data {p,p,p}
    task automatic beat(input logic [3:0] p, input logic u, input logic l,
                        input logic [AW-1:0] a, input logic [2:0] pls);
        wr_q.push_back({a, p, p, p});
        if (pls != P_NONE) pulse_q.push_back(pls);
        send(pix(p), u, l);
    endtask

    // Beat that must be discarded
    task automatic drop(input logic [3:0] p, input logic u, input logic l);
        send(pix(p), u, l);
    endtask

    task automatic probe(input logic [4:0] v, input string n);
        chk_name = n;
        chk_val  = v;
        chk_en   = 1'b1;
        @(negedge pixel_clk);
        #1 chk_en = 1'b0;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic probe_cnt(input logic [15:0] v, input string n);
        chk_name = n;
        cnt_val  = v;
        cnt_en   = 1'b1;
        @(negedge pixel_clk);
        #1 cnt_en = 1'b0;
        @(posedge pixel_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        tdata     = 24'h000000;
        tvalid    = 1'b1;
        tuser     = 1'b0;
        tlast     = 1'b0;
        fb_wready = 1'b1;
        @(posedge pixel_clk);
        #1;
        // Reset with tvalid high: nothing accepted, nothing asserted
        probe(5'b00000, "reset_c1");
        probe(5'b00000, "reset_c2");
        probe_cnt(16'h0000, "reset_cnt");
        reset = 1'b0;
        probe(5'b10000, "post_reset");
        tvalid = 1'b0;
        // Beat without tuser in SEEK is discarded
        drop(4'h9, 1'b0, 1'b0);

        // Clean frame with data-pack check on the first pixel
        chk_name = "clean";
        wr_q.push_back({3'd0, 12'hACF});
        send(24'hA5C3F0, 1'b1, 1'b0);
        beat(4'h1, 1'b0, 1'b0, 3'd1, P_NONE);
        beat(4'h2, 1'b0, 1'b0, 3'd2, P_NONE);
        beat(4'h3, 1'b0, 1'b1, 3'd3, P_NONE);
        beat(4'h4, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'h5, 1'b0, 1'b0, 3'd5, P_NONE);
        beat(4'h6, 1'b0, 1'b0, 3'd6, P_NONE);
        beat(4'h7, 1'b0, 1'b1, 3'd7, P_FD);

        // Backpressure mid-line
        chk_name = "backpressure";
        beat(4'h1, 1'b1, 1'b0, 3'd0, P_NONE);
        beat(4'h2, 1'b0, 1'b0, 3'd1, P_NONE);
        fb_wready = 1'b0;
        wr_q.push_back({3'd2, 12'h333});
        tdata  = pix(4'h3);
        tvalid = 1'b1;
        probe(5'b01000, "bp_stall1");
        probe(5'b01000, "bp_stall2");
        probe(5'b01000, "bp_stall3");
        fb_wready = 1'b1;
        chk_name = "backpressure";
        send(pix(4'h3), 1'b0, 1'b0);
        beat(4'h4, 1'b0, 1'b1, 3'd3, P_NONE);
        beat(4'h5, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'h6, 1'b0, 1'b0, 3'd5, P_NONE);
        beat(4'h7, 1'b0, 1'b0, 3'd6, P_NONE);
        beat(4'h8, 1'b0, 1'b1, 3'd7, P_FD);

        // Short line: tlast at x=2
        chk_name = "short";
        beat(4'hA, 1'b1, 1'b0, 3'd0, P_NONE);
        beat(4'hB, 1'b0, 1'b0, 3'd1, P_NONE);
        beat(4'hC, 1'b0, 1'b1, 3'd2, P_LE);
        beat(4'hD, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'hE, 1'b0, 1'b0, 3'd5, P_NONE);
        beat(4'hF, 1'b0, 1'b0, 3'd6, P_NONE);
        beat(4'h1, 1'b0, 1'b1, 3'd7, P_FD);

        // Long line: no tlast at x=3, two extras (second carries tlast)
        chk_name = "long";
        beat(4'h2, 1'b1, 1'b0, 3'd0, P_NONE);
        beat(4'h3, 1'b0, 1'b0, 3'd1, P_NONE);
        beat(4'h4, 1'b0, 1'b0, 3'd2, P_NONE);
        beat(4'h5, 1'b0, 1'b0, 3'd3, P_LE);
        drop(4'h6, 1'b0, 1'b0);
        drop(4'h7, 1'b0, 1'b1);
        beat(4'h8, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'h9, 1'b0, 1'b0, 3'd5, P_NONE);
        beat(4'hA, 1'b0, 1'b0, 3'd6, P_NONE);
        beat(4'hB, 1'b0, 1'b1, 3'd7, P_FD);

`ifdef AXIS_SINK_ERRCNT_EN
        probe_cnt(16'd2, "cnt_two");
`else
        probe_cnt(16'd0, "cnt_two");
`endif

        // Reset with a stalled write pending: write is dropped, back to SEEK
        fb_wready = 1'b0;
        chk_name = "reset_mid";
        send(pix(4'hC), 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge pixel_clk);
        #1 reset = 1'b0;
        probe(5'b10000, "reset_mid");
        fb_wready = 1'b1;
        probe_cnt(16'h0000, "reset_mid_cnt");
        drop(4'hD, 1'b0, 1'b0);

        // Mid-frame tuser at addr 5
        chk_name = "midsof";
        beat(4'h1, 1'b1, 1'b0, 3'd0, P_NONE);
        beat(4'h2, 1'b0, 1'b0, 3'd1, P_NONE);
        beat(4'h3, 1'b0, 1'b0, 3'd2, P_NONE);
        beat(4'h4, 1'b0, 1'b1, 3'd3, P_NONE);
        beat(4'h5, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'h6, 1'b1, 1'b0, 3'd0, P_FE);
        beat(4'h7, 1'b0, 1'b0, 3'd1, P_NONE);
        beat(4'h8, 1'b0, 1'b0, 3'd2, P_NONE);
        beat(4'h9, 1'b0, 1'b1, 3'd3, P_NONE);
        beat(4'hA, 1'b0, 1'b0, 3'd4, P_NONE);
        beat(4'hB, 1'b0, 1'b0, 3'd5, P_NONE);
        beat(4'hC, 1'b0, 1'b0, 3'd6, P_NONE);
        beat(4'hD, 1'b0, 1'b1, 3'd7, P_FD);
`ifdef AXIS_SINK_ERRCNT_EN
        probe_cnt(16'd1, "cnt_one");
`else
        probe_cnt(16'd0, "cnt_one");
`endif

        repeat (3) @(posedge pixel_clk);
        #1 end_req = 1'b1;
        @(negedge pixel_clk);
        #1 end_req = 1'b0;
        @(posedge pixel_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
